// File: rtl/video_pkg.sv
// Shared definitions for the video line-buffer slice: control states,
// bank-pointer sizing and modulo bank stepping.
package video_pkg;

    localparam int LATE_CNT_W = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    // Pointer width for a bank count; never narrower than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Explicit wrap so non-power-of-two bank counts step correctly.
    function automatic int bank_inc(input int ptr, input int banks);
        return (ptr >= banks - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/video_linebuf_bank.sv
// One line bank: simple dual-port RAM, single write port, registered read
// with enable so the read data holds between reads.
module video_linebuf_bank #(
    parameter int             DW     = 8,
    parameter int             AW     = 9,
    parameter logic [DW-1:0]  TRANSP = '0
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read samples the old content, so a clear-behind write in the same
    // cycle never disturbs the value returned.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rdata_q <= TRANSP;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/video_tsline_buf.sv
// N-bank TS overlay line buffer: rotating read/write banks, transparent-skip
// writes, read-with-clear-behind, post-reset clearing sweep, late detection.
module video_tsline_buf
    import video_pkg::*;
#(
    parameter int             DW     = 8,
    parameter int             AW     = 9,
    parameter int             BANKS  = 2,
    parameter logic [DW-1:0]  TRANSP = '0
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  line_start,
    input  logic                  render_done,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DW-1:0]         rd_data,
    output logic                  init_busy,
    output logic                  late,
    output logic [LATE_CNT_W-1:0] late_cnt
);

    localparam int BW    = clog2(BANKS);
    localparam int DEPTH = 2**AW;

    ctrl_state_e           state_q, state_d;
    logic [AW-1:0]         sweep_q, sweep_d;
    logic [BW-1:0]         rd_bank_q, rd_bank_d;
    logic [BW-1:0]         rd_sel_q, rd_sel_d;
    logic [BW-1:0]         wr_bank;
    logic                  late_q, late_d;
    logic [LATE_CNT_W-1:0] late_cnt_q, late_cnt_d;
    logic                  run;

    logic                  bank_we    [BANKS];
    logic [AW-1:0]         bank_waddr [BANKS];
    logic [DW-1:0]         bank_wdata [BANKS];
    logic                  bank_re    [BANKS];
    logic [DW-1:0]         bank_rdata [BANKS];

    assign run       = (state_q == ST_RUN);
    assign init_busy = !run;
    assign wr_bank   = BW'(bank_inc(int'(rd_bank_q), BANKS));

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Rotation runs during the sweep too; only late reporting waits for RUN.
    always_comb begin
        rd_bank_d  = rd_bank_q;
        rd_sel_d   = rd_sel_q;
        late_d     = 1'b0;
        late_cnt_d = late_cnt_q;
        if (line_start) begin
            rd_bank_d = BW'(bank_inc(int'(rd_bank_q), BANKS));
        end
        if (rd_en && run) begin
            rd_sel_d = rd_bank_q;
        end
        if (line_start && !render_done && run) begin
            late_d = 1'b1;
            if (late_cnt_q != {LATE_CNT_W{1'b1}}) begin
                late_cnt_d = late_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= ST_INIT;
            sweep_q    <= '0;
            rd_bank_q  <= '0;
            rd_sel_q   <= '0;
            late_q     <= 1'b0;
            late_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            rd_bank_q  <= rd_bank_d;
            rd_sel_q   <= rd_sel_d;
            late_q     <= late_d;
            late_cnt_q <= late_cnt_d;
        end
    end

    // Per-bank write port priority: sweep, then clear-behind, then renderer.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            bank_we[b]    = 1'b0;
            bank_waddr[b] = wr_addr;
            bank_wdata[b] = wr_data;
            bank_re[b]    = 1'b0;
            if (!run) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = sweep_q;
                bank_wdata[b] = TRANSP;
            end else if (BW'(b) == rd_bank_q) begin
                bank_re[b]    = rd_en;
                bank_we[b]    = rd_en;
                bank_waddr[b] = rd_addr;
                bank_wdata[b] = TRANSP;
            end else if (BW'(b) == wr_bank) begin
                bank_we[b]    = wr_en && (wr_data != TRANSP);
            end
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        video_linebuf_bank #(
            .DW     (DW),
            .AW     (AW),
            .TRANSP (TRANSP)
        ) u_bank (
            .clk     (clk),
            .res_n   (res_n),
            .we_i    (bank_we[g]),
            .waddr_i (bank_waddr[g]),
            .wdata_i (bank_wdata[g]),
            .re_i    (bank_re[g]),
            .raddr_i (rd_addr),
            .rdata_o (bank_rdata[g])
        );
    end

    assign rd_data  = bank_rdata[rd_sel_q];
    assign late     = late_q;
    assign late_cnt = late_cnt_q;

endmodule

// File: tb/tb_video_tsline_buf.sv
// Directed bench for video_tsline_buf: a 2-bank 512-deep instance and a
// 3-bank 16-deep instance sharing clock and reset.
module tb_video_tsline_buf;

    logic clk;
    logic res_n;

    logic       line_start_a, render_done_a, wr_en_a, rd_en_a;
    logic [8:0] wr_addr_a, rd_addr_a;
    logic [7:0] wr_data_a, rd_data_a;
    logic       init_busy_a, late_a;
    logic [7:0] late_cnt_a;

    logic       line_start_b, render_done_b, wr_en_b, rd_en_b;
    logic [3:0] wr_addr_b, rd_addr_b;
    logic [7:0] wr_data_b, rd_data_b;
    logic       init_busy_b, late_b;
    logic [7:0] late_cnt_b;

    logic [7:0] exp_q[$];
    int total;
    int bad;

    video_tsline_buf #(.DW(8), .AW(9), .BANKS(2), .TRANSP(8'h00)) dut_a (
        .clk(clk), .res_n(res_n), .line_start(line_start_a), .render_done(render_done_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .init_busy(init_busy_a), .late(late_a), .late_cnt(late_cnt_a)
    );

    video_tsline_buf #(.DW(8), .AW(4), .BANKS(3), .TRANSP(8'h00)) dut_b (
        .clk(clk), .res_n(res_n), .line_start(line_start_b), .render_done(render_done_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .init_busy(init_busy_b), .late(late_b), .late_cnt(late_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] got);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty got=%0h exp=none", tag, got);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(got), 32'(e));
        end
    endtask

    task automatic wr_a(input logic [8:0] a, input logic [7:0] d);
        wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
        tick();
        wr_en_a = 1'b0;
    endtask

    task automatic rd_a(input logic [8:0] a, input logic [7:0] e, input string tag);
        rd_en_a = 1'b1; rd_addr_a = a;
        exp_q.push_back(e);
        tick();
        rd_en_a = 1'b0;
        sb_check(tag, rd_data_a);
    endtask

    task automatic ls_a(input logic done);
        line_start_a = 1'b1; render_done_a = done;
        tick();
        line_start_a = 1'b0; render_done_a = 1'b1;
    endtask

    task automatic step_b(input logic [3:0] a, input logic we, input logic [7:0] wd,
                          input logic re, input logic [7:0] e, input string tag);
        wr_en_b = we; wr_addr_b = a; wr_data_b = wd;
        rd_en_b = re; rd_addr_b = a;
        if (re) exp_q.push_back(e);
        tick();
        wr_en_b = 1'b0; rd_en_b = 1'b0;
        if (re) sb_check(tag, rd_data_b);
    endtask

    task automatic ls_b();
        line_start_b = 1'b1;
        tick();
        line_start_b = 1'b0;
    endtask

    initial begin
        int cnt;
        total = 0; bad = 0;
        res_n = 1'b0;
        line_start_a = 1'b0; render_done_a = 1'b1; wr_en_a = 1'b0; rd_en_a = 1'b0;
        wr_addr_a = '0; rd_addr_a = '0; wr_data_a = '0;
        line_start_b = 1'b0; render_done_b = 1'b1; wr_en_b = 1'b0; rd_en_b = 1'b0;
        wr_addr_b = '0; rd_addr_b = '0; wr_data_b = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy_a", 32'(init_busy_a), 32'd1);
        chk("rst_busy_b", 32'(init_busy_b), 32'd1);
        chk("rst_rd_data", 32'(rd_data_a), 32'h00);
        chk("rst_late", 32'(late_a), 32'd0);
        chk("rst_late_cnt", 32'(late_cnt_a), 32'd0);
        res_n = 1'b1;

        // Sweep: reads ignored, late suppressed, two rotations return rd_bank to 0
        rd_a(9'd5, 8'h00, "sweep_rd");
        cnt = 1;
        ls_a(1'b0);
        cnt++;
        chk("late_suppressed", 32'(late_a), 32'd0);
        ls_a(1'b0);
        cnt++;
        chk("late_cnt_suppressed", 32'(late_cnt_a), 32'd0);
        while (init_busy_a && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk("sweep_len", 32'(cnt), 32'd512);
        chk("busy_b_done", 32'(init_busy_b), 32'd0);

        // Basic write, rotate, read, clear-behind
        wr_a(9'd10, 8'h5A);
        wr_a(9'd11, 8'h00);
        ls_a(1'b1);
        chk("late_ontime", 32'(late_a), 32'd0);
        rd_a(9'd10, 8'h5A, "rd10");
        rd_a(9'd11, 8'h00, "rd11");
        rd_a(9'd10, 8'h00, "rd10_cleared");

        // Transparent skip and later-wins
        wr_a(9'd20, 8'h33);
        wr_a(9'd20, 8'h00);
        ls_a(1'b1);
        rd_a(9'd20, 8'h33, "transp_skip");
        tick();
        tick();
        chk("rd_hold", 32'(rd_data_a), 32'h33);
        wr_a(9'd21, 8'h33);
        wr_a(9'd21, 8'h44);
        ls_a(1'b1);
        rd_a(9'd21, 8'h44, "later_wins");

        // Write in the line_start cycle lands in the pre-rotation write bank
        wr_en_a = 1'b1; wr_addr_a = 9'd30; wr_data_a = 8'h77;
        line_start_a = 1'b1; render_done_a = 1'b1;
        tick();
        wr_en_a = 1'b0; line_start_a = 1'b0;
        rd_a(9'd30, 8'h77, "ls_cycle_write");

        // Three-bank rotation on the second instance
        for (int i = 0; i < 4; i++) step_b(4'(i), 1'b1, 8'(8'h10 + i), 1'b0, 8'h00, "b_l0");
        ls_b();
        for (int i = 0; i < 4; i++) step_b(4'(i), 1'b1, 8'(8'h20 + i), 1'b1, 8'(8'h10 + i), "b_line0");
        ls_b();
        for (int i = 0; i < 4; i++) step_b(4'(i), 1'b1, 8'(8'h30 + i), 1'b1, 8'(8'h20 + i), "b_line1");
        ls_b();
        for (int i = 0; i < 4; i++) step_b(4'(i), 1'b0, 8'h00, 1'b1, 8'(8'h30 + i), "b_line2");
        ls_b();
        for (int i = 0; i < 4; i++) step_b(4'(i), 1'b0, 8'h00, 1'b1, 8'h00, "b_cleared");
        chk("b_late_cnt", 32'(late_cnt_b), 32'd0);

        // Late detection and saturation
        for (int i = 0; i < 3; i++) begin
            ls_a(1'b0);
            chk("late_pulse", 32'(late_a), 32'd1);
            tick();
            chk("late_one_cycle", 32'(late_a), 32'd0);
        end
        chk("late_cnt3", 32'(late_cnt_a), 32'd3);
        line_start_a = 1'b1; render_done_a = 1'b0;
        repeat (297) tick();
        line_start_a = 1'b0; render_done_a = 1'b1;
        tick();
        chk("late_cnt_sat", 32'(late_cnt_a), 32'd255);

        // Reset mid-operation with live data
        wr_a(9'd40, 8'h99);
        ls_a(1'b1);
        rd_a(9'd40, 8'h99, "pre_reset_rd");
        wr_a(9'd50, 8'hAB);
        res_n = 1'b0;
        #2;
        chk("midrst_rd_data", 32'(rd_data_a), 32'h00);
        chk("midrst_late_cnt", 32'(late_cnt_a), 32'd0);
        chk("midrst_busy", 32'(init_busy_a), 32'd1);
        @(posedge clk);
        #1;
        res_n = 1'b1;
        cnt = 0;
        while (init_busy_a && cnt < 2000) begin
            tick();
            cnt++;
        end
        chk("resweep_len", 32'(cnt), 32'd512);
        rd_a(9'd50, 8'h00, "post_sweep_rd50");
        rd_a(9'd40, 8'h00, "post_sweep_rd40");
        ls_a(1'b1);
        rd_a(9'd50, 8'h00, "post_sweep_rd50_b1");
        rd_a(9'd40, 8'h00, "post_sweep_rd40_b1");

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_tsline_buf.md
# video_tsline_buf

Parametrised N-bank line buffer for the tile/sprite (TS) overlay layer, placed between the TS renderer and the pixel render stage. It generalises the fixed two-bank 512×8 TS line pair to configurable pixel width, depth and bank count. It adds:

- transparent-skip writes,
- read-with-clear-behind,
- a post-reset clearing sweep,
- late-render detection.

## Interface

Parameters:
- DW, 8: pixel width in bits.
- AW, 9: address width; each bank holds 2^AW pixels.
- BANKS, 2: number of banks, legal values 2–4.
- TRANSP, 0: transparent pixel value (DW bits).

Ports:
- clk  in  1  system clock.
- res_n  in  1  reset, asynchronous, active-low.
- line_start  in  1  one-cycle pulse; rotates banks.
- render_done  in  1  renderer finished the current write bank; level, sampled at line_start.
- wr_en  in  1  write strobe from the renderer.
- wr_addr  in  AW  write pixel address.
- wr_data  in  DW  write pixel.
- rd_en  in  1  display read strobe (c3-rate).
- rd_addr  in  AW  display pixel address.
- rd_data  out  DW  registered read data.
- init_busy  out  1  clearing sweep in progress.
- late  out  1  one-cycle pulse: line_start arrived with render_done low.
- late_cnt  out  8  saturating count of late events.

## Operation

Bank pointers:
- rd_bank (display bank) resets to 0.
- wr_bank is always (rd_bank+1) mod BANKS.
- On line_start: rd_bank ← (rd_bank+1) mod BANKS, so the just-rendered bank becomes the display bank.
- When BANKS>2, the banks other than rd_bank and wr_bank are idle and hold their content.

Write path:
- Writes go to wr_bank only.
- Write occurs when wr_en=1 and wr_data≠TRANSP.
- Transparent pixels are dropped, so earlier non-transparent pixels survive.
- Among non-transparent writes, the later write wins.

Read path with clear-behind:
- When rd_en=1, rd_bank[rd_addr] is read and, in the same cycle, written with TRANSP.
- The bank therefore arrives empty when it next becomes a write bank.
- No explicit clear pass is needed.

Init sweep:
- Reset release starts an address counter 0..2^AW−1 that writes TRANSP to the same address in every bank each cycle.
- init_busy is high for exactly 2^AW cycles.
- During the sweep, wr_en and rd_en are ignored, rd_data is held at TRANSP, and line_start rotates pointers normally but late is suppressed.

Late detection:
- On line_start with render_done=0 and init_busy=0: late pulses for one cycle and late_cnt increments, saturating at 255.
- The rotation still happens; partial content is displayed.

Width rules:
- Addresses wrap naturally within AW bits.
- Bank pointer width is clog2(BANKS); modulo arithmetic is explicit (no power-of-two reliance for BANKS=3).

## Timing

Reset values:
- rd_bank=0, rd_data=TRANSP, late=0, late_cnt=0.
- init_busy=1 asynchronously while res_n=0 and until the sweep ends.

Latency:
- rd_data is valid one clk after rd_en.
- rd_data holds its value when rd_en=0.

Same-address read and clear: read-before-write; rd_data returns the old value. A back-to-back second read of the same address returns TRANSP.

Cycle coinciding with line_start:
- rd_en and wr_en that cycle use the pre-rotation banks.
- The new mapping is effective from the next cycle.

Bank independence:
- Write and read target different banks, so there is never a port conflict.
- Each bank has one write port, muxed between three sources in priority order: init sweep, clear-behind (when it is rd_bank), renderer (when it is wr_bank).

Reset mid-operation: all pointers return to reset values, the sweep restarts and in-flight data is lost.

## Structure

- Shared package (video_pkg) holds: bank pointer width function clog2, the bank index increment-modulo function, and the late_cnt width constant (8).
- Natural sub-module: video_linebuf_bank, one simple dual-port RAM (registered read, one write port, 2^AW×DW). It is instantiated BANKS times via generate; the top holds the pointer FSM, sweep counter, write muxing and read-data mux.
- Control states: INIT (sweep) → RUN; reset always re-enters INIT.

## Test plan

1. Reset, DW=8, AW=9, BANKS=2 → init_busy high for 512 cycles, then low; reads during the sweep return 0.
2. After init: write 0x5A at address 10 and 0x00 at address 11; pulse line_start; read 10 then 11 → rd_data 0x5A then 0x00 one cycle later; re-read 10 → 0x00 (cleared).
3. Write 0x33 then 0x00 to the same address, rotate, read → 0x33 (transparent skipped). Write 0x33 then 0x44, rotate, read → 0x44.
4. BANKS=3: render distinct patterns over three lines → each line is displayed exactly one line_start after it was rendered; rd_bank sequence 0,1,2,0.
5. line_start with render_done=0 three times → three late pulses, late_cnt=3; force 300 events → late_cnt stays 255.
6. Assert res_n low mid-line with data in banks → rd_data=0 and late_cnt=0 immediately; the sweep reruns; reads after the sweep return 0.
